// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter that merges N_REQ requester word streams into one FIFO write port.
// Latency : one arbitration cycle per grant, then combinational ack/w_inc/wdata on each transfer cycle.
// Backpr. : w_full stalls the current burst (no ack, no w_inc); burst_cnt and owner hold until it clears.
//
// Ports
//   w_clk, wrst     : FIFO write clock, asynchronous active-high reset
//   req, req_data   : per-requester word-ready flag and word (requester i on [i*D_SIZE +: D_SIZE])
//   ack             : one-hot pulse, requester word consumed this cycle
//   w_full          : FIFO full flag (write-clock domain)
//   w_inc, wdata    : FIFO write enable and write data
//   busy, owner     : burst in progress, index of current grant holder (0 when idle)
//   burst_cnt       : words transferred in the current burst
module fifo_wr_arbiter #(
  parameter int D_SIZE    = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    w_clk,
  input  logic                    wrst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*D_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    w_full,
  output logic                    w_inc,
  output logic [D_SIZE-1:0]       wdata,
  output logic                    busy,
  output logic [2:0]              owner,
  output logic [3:0]              burst_cnt
);

  // Width of a requester index; N_REQ is at least 2 so this is never zero.
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;

  // ---------------------------------------------------------------------------
  // Circular first-one search starting at rr_ptr.
  // Scanning from the farthest offset down to offset 0 lets the closest hit
  // overwrite any farther one, so the final value is the first high req.
  // ---------------------------------------------------------------------------
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   scan;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N_REQ)) begin
        scan = scan - (IW+1)'(N_REQ);
      end
      if (req[scan[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[IW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Owner's request flag and data word. Data is not registered: requesters
  // hold it stable until their ack.
  // ---------------------------------------------------------------------------
  logic              owner_req;
  logic [D_SIZE-1:0] owner_dat;

  always_comb begin
    owner_req = 1'b0;
    owner_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req = req[i];
        owner_dat = req_data[i*D_SIZE +: D_SIZE];
      end
    end
  end

  // Priority after the current owner, wrapping at N_REQ (need not be a power of two).
  logic [IW-1:0] rr_next;
  assign rr_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // This transfer would be the last word the burst may carry.
  logic last_word;
  assign last_word = (burst_cnt_q == 4'(MAX_BURST - 1));

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  logic xfer;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    xfer        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d     = pick_idx;
          burst_cnt_d = 4'd0;
          state_d     = ST_BURST;
        end
      end

      ST_BURST: begin
        if (!owner_req) begin
          // Owner withdrew; ends the burst even when the FIFO is full.
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next;
          owner_d  = '0;
        end else if (!w_full) begin
          xfer        = 1'b1;
          burst_cnt_d = burst_cnt_q + 4'd1;
          if (last_word) begin
            state_d  = ST_IDLE;
            rr_ptr_d = rr_next;
            owner_d  = '0;
          end
        end
        // Otherwise stalled on w_full: everything holds.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything is gated by the registered state so reset forces
  // them low immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign busy      = (state_q == ST_BURST);
  assign w_inc     = xfer;
  assign ack       = xfer ? (ONE_HOT0 << owner_q) : '0;
  assign wdata     = xfer ? owner_dat : '0;
  assign owner     = 3'(owner_q);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: default instance (N_REQ=4, MAX_BURST=4)
// plus a second instance with N_REQ=2, MAX_BURST=1.
module tb_fifo_wr_arbiter;

  localparam logic [31:0] DAT  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [15:0] DAT2 = {8'hB1, 8'hB0};

  logic        w_clk = 1'b0;
  logic        wrst  = 1'b1;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        w_full;
  logic        w_inc;
  logic [7:0]  wdata;
  logic        busy;
  logic [2:0]  owner;
  logic [3:0]  burst_cnt;

  logic [1:0]  req2;
  logic [15:0] req_data2;
  logic [1:0]  ack2;
  logic        w_full2;
  logic        w_inc2;
  logic [7:0]  wdata2;
  logic        busy2;
  logic [2:0]  owner2;
  logic [3:0]  burst_cnt2;

  int checks = 0;
  int passes = 0;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(.D_SIZE(8), .N_REQ(4), .MAX_BURST(4)) dut (
    .w_clk(w_clk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .w_full(w_full), .w_inc(w_inc), .wdata(wdata), .busy(busy), .owner(owner),
    .burst_cnt(burst_cnt)
  );

  fifo_wr_arbiter #(.D_SIZE(8), .N_REQ(2), .MAX_BURST(1)) dut2 (
    .w_clk(w_clk), .wrst(wrst), .req(req2), .req_data(req_data2), .ack(ack2),
    .w_full(w_full2), .w_inc(w_inc2), .wdata(wdata2), .busy(busy2), .owner(owner2),
    .burst_cnt(burst_cnt2)
  );

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    wrst      = 1'b1;
    req       = '0;
    req2      = '0;
    w_full    = 1'b0;
    w_full2   = 1'b0;
    req_data  = DAT;
    req_data2 = DAT2;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got, exp;
    wrst = 1'b1; req = 4'b1111; req_data = DAT; w_full = 1'b0;
    req2 = 2'b11; req_data2 = DAT2; w_full2 = 1'b0;
    #2;
    got = {busy, owner, burst_cnt, w_inc, ack, wdata};
    checks++;
    if (got !== 21'd0) $display("FAIL reset_outputs: got %h expected 000000", got);
    else passes++;
    checks++;
    if ({busy2, owner2, burst_cnt2, w_inc2, ack2, wdata2} !== 19'd0)
      $display("FAIL reset_outputs_dut2: got %h expected 0",
               {busy2, owner2, burst_cnt2, w_inc2, ack2, wdata2});
    else passes++;
    tick(); tick();
    wrst = 1'b0;
    #2;
    checks++;
    if ({busy, w_inc, ack} !== 6'd0) $display("FAIL reset_release_idle: got %h expected 00", {busy, w_inc, ack});
    else passes++;
    tick(); #2;
    got = {busy, owner, burst_cnt, w_inc, ack, wdata};
    exp = {1'b1, 3'd0, 4'd0, 1'b1, 4'b0001, 8'hA0};
    checks++;
    if (got !== exp) $display("FAIL reset_first_grant: got %h expected %h", got, exp);
    else passes++;
    req = '0; req2 = '0;
  endtask

  task automatic test_single();
    logic [20:0] got, exp;
    int ph;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 11; c++) begin
      #2;
      ph = c % 5;
      checks++;
      if (ph == 0) begin
        if ({busy, owner, w_inc, ack, wdata} !== 17'd0)
          $display("FAIL single_idle c=%0d: got %h expected 0", c, {busy, owner, w_inc, ack, wdata});
        else passes++;
      end else begin
        got = {busy, owner, burst_cnt, w_inc, ack, wdata};
        exp = {1'b1, 3'd2, 4'(ph - 1), 1'b1, 4'b0100, 8'hA2};
        if (got !== exp) $display("FAIL single_burst c=%0d: got %h expected %h", c, got, exp);
        else passes++;
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_all_req();
    int          wc [4];
    logic [7:0]  fifo_q [$];
    logic [7:0]  ack_q [$];
    logic [20:0] got, exp;
    int          ph, eo, bad;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) wc[i] = 0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 16 + wc[i]);
      #2;
      ph = c % 5;
      eo = (c / 5) % 4;
      if (w_inc) fifo_q.push_back(wdata);
      for (int i = 0; i < 4; i++) if (ack[i]) ack_q.push_back(req_data[i*8 +: 8]);
      checks++;
      if (ph == 0) begin
        if ({busy, owner, w_inc, ack} !== 9'd0)
          $display("FAIL all_idle c=%0d: got %h expected 0", c, {busy, owner, w_inc, ack});
        else passes++;
      end else begin
        got = {busy, owner, burst_cnt, w_inc, ack, wdata};
        exp = {1'b1, 3'(eo), 4'(ph - 1), 1'b1, 4'(1 << eo), 8'(eo * 16 + wc[eo])};
        if (got !== exp) $display("FAIL all_burst c=%0d: got %h expected %h", c, got, exp);
        else passes++;
        wc[eo]++;
      end
      tick();
    end
    checks++;
    if (fifo_q.size() != 20 || ack_q.size() != 20)
      $display("FAIL all_word_count: got fifo=%0d ack=%0d expected 20", fifo_q.size(), ack_q.size());
    else passes++;
    bad = 0;
    for (int i = 0; i < fifo_q.size() && i < ack_q.size(); i++) if (fifo_q[i] !== ack_q[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL all_order: got %0d out-of-order words expected 0", bad);
    else passes++;
    req = '0;
  endtask

  task automatic test_stall();
    int full_t [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int busy_t [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int xf_t   [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    int cnt_t  [9] = '{0, 0, 1, 2, 2, 2, 2, 3, 0};
    logic [20:0] got, exp;
    logic ex;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      w_full = (full_t[c] != 0);
      ex = (xf_t[c] != 0);
      #2;
      checks++;
      if (busy_t[c] != 0) begin
        got = {busy, owner, burst_cnt, w_inc, ack, wdata};
        exp = {1'b1, 3'd0, 4'(cnt_t[c]), ex, ex ? 4'b0001 : 4'b0000, ex ? 8'hA0 : 8'h00};
        if (got !== exp) $display("FAIL stall c=%0d: got %h expected %h", c, got, exp);
        else passes++;
      end else begin
        if ({busy, owner, w_inc, ack} !== 9'd0)
          $display("FAIL stall_idle c=%0d: got %h expected 0", c, {busy, owner, w_inc, ack});
        else passes++;
      end
      checks++;
      if (w_inc && w_full) $display("FAIL stall_winc_full c=%0d: got w_inc=1 expected 0", c);
      else passes++;
      tick();
    end
    w_full = 1'b0; req = '0;
  endtask

  task automatic test_drop();
    logic [3:0] req_t [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b1001, 4'b1001};
    int own_t  [6] = '{0, 1, 1, 1, 0, 3};
    int busy_t [6] = '{0, 1, 1, 1, 0, 1};
    int cnt_t  [6] = '{0, 0, 1, 2, 0, 0};
    int xf_t   [6] = '{0, 1, 1, 0, 0, 1};
    logic [31:0] dv;
    logic [20:0] got, exp;
    logic ex;
    dv = DAT;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req = req_t[c];
      ex = (xf_t[c] != 0);
      #2;
      checks++;
      if (busy_t[c] != 0) begin
        got = {busy, owner, burst_cnt, w_inc, ack, wdata};
        exp = {1'b1, 3'(own_t[c]), 4'(cnt_t[c]), ex, ex ? 4'(1 << own_t[c]) : 4'b0000,
               ex ? dv[own_t[c]*8 +: 8] : 8'h00};
        if (got !== exp) $display("FAIL drop c=%0d: got %h expected %h", c, got, exp);
        else passes++;
      end else begin
        if ({busy, owner, w_inc, ack} !== 9'd0)
          $display("FAIL drop_idle c=%0d: got %h expected 0", c, {busy, owner, w_inc, ack});
        else passes++;
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_drop_full();
    logic [3:0] req_t [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001};
    int full_t [5] = '{0, 0, 1, 0, 0};
    int own_t  [5] = '{0, 1, 1, 0, 0};
    int busy_t [5] = '{0, 1, 1, 0, 1};
    int cnt_t  [5] = '{0, 0, 1, 0, 0};
    int xf_t   [5] = '{0, 1, 0, 0, 1};
    logic [31:0] dv;
    logic [20:0] got, exp;
    logic ex;
    dv = DAT;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = req_t[c];
      w_full = (full_t[c] != 0);
      ex = (xf_t[c] != 0);
      #2;
      checks++;
      if (busy_t[c] != 0) begin
        got = {busy, owner, burst_cnt, w_inc, ack, wdata};
        exp = {1'b1, 3'(own_t[c]), 4'(cnt_t[c]), ex, ex ? 4'(1 << own_t[c]) : 4'b0000,
               ex ? dv[own_t[c]*8 +: 8] : 8'h00};
        if (got !== exp) $display("FAIL drop_full c=%0d: got %h expected %h", c, got, exp);
        else passes++;
      end else begin
        if ({busy, owner, w_inc, ack} !== 9'd0)
          $display("FAIL drop_full_idle c=%0d: got %h expected 0", c, {busy, owner, w_inc, ack});
        else passes++;
      end
      tick();
    end
    w_full = 1'b0; req = '0;
  endtask

  task automatic test_reset_mid();
    logic [20:0] got, exp;
    do_reset();
    req = 4'b1000;
    tick(); tick(); #2;
    got = {busy, owner, burst_cnt, w_inc, ack, wdata};
    exp = {1'b1, 3'd3, 4'd1, 1'b1, 4'b1000, 8'hA3};
    checks++;
    if (got !== exp) $display("FAIL rstmid_setup: got %h expected %h", got, exp);
    else passes++;
    #1 wrst = 1'b1;
    #1;
    got = {busy, owner, burst_cnt, w_inc, ack, wdata};
    checks++;
    if (got !== 21'd0) $display("FAIL rstmid_async: got %h expected 000000", got);
    else passes++;
    tick(); #2;
    checks++;
    if ({busy, w_inc, ack} !== 6'd0) $display("FAIL rstmid_held: got %h expected 00", {busy, w_inc, ack});
    else passes++;
    tick();
    wrst = 1'b0;
    req  = 4'b1010;
    #2;
    checks++;
    if ({busy, owner, w_inc, ack} !== 9'd0)
      $display("FAIL rstmid_idle: got %h expected 0", {busy, owner, w_inc, ack});
    else passes++;
    tick(); #2;
    got = {busy, owner, burst_cnt, w_inc, ack, wdata};
    exp = {1'b1, 3'd1, 4'd0, 1'b1, 4'b0010, 8'hA1};
    checks++;
    if (got !== exp) $display("FAIL rstmid_restart: got %h expected %h", got, exp);
    else passes++;
    req = '0;
  endtask

  task automatic test_sweep();
    logic [18:0] got, exp;
    int eo, nxt, grants;
    do_reset();
    req2 = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #2;
      checks++;
      if ((c % 2) == 0) begin
        if ({busy2, w_inc2, ack2} !== 4'd0)
          $display("FAIL sweep_idle c=%0d: got %h expected 0", c, {busy2, w_inc2, ack2});
        else passes++;
      end else begin
        eo  = (c / 2) % 2;
        got = {busy2, owner2, burst_cnt2, w_inc2, ack2, wdata2};
        exp = {1'b1, 3'(eo), 4'd0, 1'b1, 2'(1 << eo), (eo == 1) ? 8'hB1 : 8'hB0};
        if (got !== exp) $display("FAIL sweep_alt c=%0d: got %h expected %h", c, got, exp);
        else passes++;
      end
      tick();
    end
    nxt = 0;
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      w_full2 = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (w_inc2 && w_full2) $display("FAIL sweep_winc_full c=%0d: got w_inc=1 expected 0", c);
      else passes++;
      checks++;
      if ($countones(ack2) > 1 || (w_inc2 != (ack2 != 2'b00)))
        $display("FAIL sweep_ack_onehot c=%0d: got ack=%b w_inc=%b expected one-hot with w_inc", c, ack2, w_inc2);
      else passes++;
      if (w_inc2) begin
        checks++;
        if (ack2 !== 2'(1 << nxt)) $display("FAIL sweep_rotation c=%0d: got %b expected %b", c, ack2, 2'(1 << nxt));
        else passes++;
        nxt = 1 - nxt;
        grants++;
      end
      tick();
    end
    checks++;
    if (grants < 5) $display("FAIL sweep_grants: got %0d expected at least 5", grants);
    else passes++;
    w_full2 = 1'b0; req2 = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_stall();
    test_drop();
    test_drop_full();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
